// File: rtl/alu_addr_sequencer.sv
// Effective-address sequencer for the 8-bit ALU: low byte in LO, optional high-byte fixup in HI.
// Handles absolute-indexed, zero-page-indexed and relative-branch addressing.
module alu_addr_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [1:0]  mode,
  input  logic [15:0] base,
  input  logic [7:0]  index,
  input  logic        force_fix,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_carry_in,
  output logic [7:0]  alu_operation,
  input  logic [8:0]  alu_f,
  output logic        busy,
  output logic        done,
  output logic [15:0] addr,
  output logic        page_cross,
  output logic [1:0]  fsm_state
);

  // Request handshake: req_valid is a single-cycle start strobe that is
  // accepted only in IDLE; it is ignored, not queued, in every other state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ABS = 2'b00;
  localparam logic [1:0] MODE_ZP  = 2'b01;
  localparam logic [1:0] MODE_REL = 2'b10;

  localparam logic [7:0] OP_ADD = 8'h80;
  localparam logic [7:0] OP_ADC = 8'h60;

  state_t      state;
  state_t      state_next;

  logic [15:0] base_q;
  logic [7:0]  index_q;
  logic [1:0]  mode_q;
  logic        force_q;
  logic [7:0]  lo_q;
  logic        c_q;
  logic        need_q;

  logic        need;
  logic        take_hi;
  logic [7:0]  skip_hi;

  // A negative branch offset borrows from the high byte unless the low add carried.
  always_comb begin
    need = 1'b0;
    case (mode_q)
      MODE_ABS: need = alu_f[8];
      MODE_ZP:  need = 1'b0;
      MODE_REL: need = index_q[7] ? ~alu_f[8] : alu_f[8];
      default:  need = alu_f[8];
    endcase
  end

  assign take_hi = need | (force_q & (mode_q != MODE_ZP));
  assign skip_hi = (mode_q == MODE_ZP) ? 8'h00 : base_q[15:8];

  always_comb begin
    state_next    = state;
    alu_a         = 8'h00;
    alu_b         = 8'h00;
    alu_carry_in  = 1'b0;
    alu_operation = 8'h00;
    case (state)
      S_IDLE: begin
        if (req_valid) state_next = S_LO;
      end
      S_LO: begin
        alu_a         = base_q[7:0];
        alu_b         = index_q;
        alu_operation = OP_ADD;
        state_next    = take_hi ? S_HI : S_DONE;
      end
      S_HI: begin
        alu_a         = base_q[15:8];
        alu_b         = ((mode_q == MODE_REL) && index_q[7]) ? 8'hFF : 8'h00;
        alu_carry_in  = c_q;
        alu_operation = OP_ADC;
        state_next    = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      base_q     <= 16'h0000;
      index_q    <= 8'h00;
      mode_q     <= MODE_ABS;
      force_q    <= 1'b0;
      lo_q       <= 8'h00;
      c_q        <= 1'b0;
      need_q     <= 1'b0;
      addr       <= 16'h0000;
      page_cross <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            base_q  <= base;
            index_q <= index;
            mode_q  <= (mode == 2'b11) ? MODE_ABS : mode;
            force_q <= force_fix;
          end
        end
        S_LO: begin
          lo_q   <= alu_f[7:0];
          c_q    <= alu_f[8];
          need_q <= need;
          // Without a fixup the address is complete now; zp drops the carry.
          if (!take_hi) begin
            addr       <= {skip_hi, alu_f[7:0]};
            page_cross <= need;
          end
        end
        S_HI: begin
          addr       <= {alu_f[7:0], lo_q};
          page_cross <= need_q;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_addr_sequencer.sv
// Directed bench for alu_addr_sequencer with a behavioural 8-bit ALU attached.
// Drives and samples on the falling edge; expected addresses go through exp_q.
module tb_alu_addr_sequencer;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [1:0]  mode;
  logic [15:0] base;
  logic [7:0]  index;
  logic        force_fix;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_carry_in;
  logic [7:0]  alu_operation;
  logic [8:0]  alu_f;
  logic        busy;
  logic        done;
  logic [15:0] addr;
  logic        page_cross;
  logic [1:0]  fsm_state;

  int n_checks;
  int n_errors;
  logic [15:0] exp_q[$];

  // transaction observations filled by run_req
  logic [7:0]  lo_a, lo_b, lo_op, hi_a, hi_b, hi_op;
  logic        lo_cin, hi_cin, saw_hi, got_pc;
  logic [15:0] got_addr;
  int          n_cyc;

  alu_addr_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .mode          (mode),
    .base          (base),
    .index         (index),
    .force_fix     (force_fix),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_carry_in  (alu_carry_in),
    .alu_operation (alu_operation),
    .alu_f         (alu_f),
    .busy          (busy),
    .done          (done),
    .addr          (addr),
    .page_cross    (page_cross),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational ALU: 100 = add without carry, 011 = ADC, otherwise OR
  always_comb begin
    case (alu_operation[7:5])
      3'b100:  alu_f = {1'b0, alu_a} + {1'b0, alu_b};
      3'b011:  alu_f = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
      default: alu_f = {1'b0, alu_a | alu_b};
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: one request, records LO/HI outputs, waits (bounded) for done
  task automatic run_req(input logic [1:0] m, input logic [15:0] b, input logic [7:0] i,
                         input logic f, input logic [15:0] exp_addr);
    logic [15:0] exp;
    exp_q.push_back(exp_addr);
    @(negedge clk);
    req_valid = 1'b1; mode = m; base = b; index = i; force_fix = f;
    @(negedge clk);
    req_valid = 1'b0;
    n_cyc  = 1;
    lo_a   = alu_a; lo_b = alu_b; lo_op = alu_operation; lo_cin = alu_carry_in;
    saw_hi = 1'b0;
    hi_a = 8'h00; hi_b = 8'h00; hi_op = 8'h00; hi_cin = 1'b0;
    while (!done && n_cyc < 8) begin
      @(negedge clk);
      n_cyc++;
      if (fsm_state == 2'd2) begin
        saw_hi = 1'b1;
        hi_a = alu_a; hi_b = alu_b; hi_op = alu_operation; hi_cin = alu_carry_in;
      end
    end
    if (!done) check_val("done_timeout", 32'd0, 32'd1);
    got_addr = addr;
    got_pc   = page_cross;
    exp = exp_q.pop_front();
    check_val("addr", {16'h0, addr}, {16'h0, exp});
    @(negedge clk);
    check_val("done_pulse", {31'h0, done}, 32'd0);
    check_val("addr_hold", {16'h0, addr}, {16'h0, exp});
    check_val("pc_hold", {31'h0, page_cross}, {31'h0, got_pc});
  endtask

  initial begin
    int n_done;
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; req_valid = 1'b0; mode = 2'b00; base = 16'h0; index = 8'h0; force_fix = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rst_busy", {31'h0, busy}, 32'd0);
    check_val("rst_done", {31'h0, done}, 32'd0);
    check_val("rst_addr", {16'h0, addr}, 32'd0);
    check_val("rst_pc", {31'h0, page_cross}, 32'd0);
    check_val("idle_alu", {7'h0, alu_a, alu_b, alu_carry_in, alu_operation}, 32'd0);

    // abs, no page cross
    run_req(2'b00, 16'h12F0, 8'h05, 1'b0, 16'h12F5);
    check_val("abs_lo_a", {24'h0, lo_a}, 32'hF0);
    check_val("abs_lo_b", {24'h0, lo_b}, 32'h05);
    check_val("abs_lo_op", {24'h0, lo_op}, 32'h80);
    check_val("abs_lo_cin", {31'h0, lo_cin}, 32'd0);
    check_val("abs_cyc", n_cyc, 2);
    check_val("abs_pc", {31'h0, got_pc}, 32'd0);

    // abs, page cross
    run_req(2'b00, 16'h12F0, 8'h20, 1'b0, 16'h1310);
    check_val("absx_hi_a", {24'h0, hi_a}, 32'h12);
    check_val("absx_hi_b", {24'h0, hi_b}, 32'h00);
    check_val("absx_hi_cin", {31'h0, hi_cin}, 32'd1);
    check_val("absx_hi_op", {24'h0, hi_op}, 32'h60);
    check_val("absx_cyc", n_cyc, 3);
    check_val("absx_pc", {31'h0, got_pc}, 32'd1);

    // zp wrap, HI skipped
    run_req(2'b01, 16'h00F0, 8'h20, 1'b0, 16'h0010);
    check_val("zp_cyc", n_cyc, 2);
    check_val("zp_pc", {31'h0, got_pc}, 32'd0);
    check_val("zp_no_hi", {31'h0, saw_hi}, 32'd0);

    // zp ignores force_fix
    run_req(2'b01, 16'h0080, 8'h10, 1'b1, 16'h0090);
    check_val("zpf_cyc", n_cyc, 2);

    // relative backward across page
    run_req(2'b10, 16'h8005, 8'hF0, 1'b0, 16'h7FF5);
    check_val("relb_hi_a", {24'h0, hi_a}, 32'h80);
    check_val("relb_hi_b", {24'h0, hi_b}, 32'hFF);
    check_val("relb_hi_cin", {31'h0, hi_cin}, 32'd0);
    check_val("relb_cyc", n_cyc, 3);
    check_val("relb_pc", {31'h0, got_pc}, 32'd1);

    // relative forward, same page
    run_req(2'b10, 16'h8005, 8'h10, 1'b0, 16'h8015);
    check_val("relf_cyc", n_cyc, 2);
    check_val("relf_pc", {31'h0, got_pc}, 32'd0);

    // relative backward within page (carry out cancels the borrow)
    run_req(2'b10, 16'h8085, 8'hF0, 1'b0, 16'h8075);
    check_val("relbn_cyc", n_cyc, 2);
    check_val("relbn_pc", {31'h0, got_pc}, 32'd0);

    // forced fixup without a cross
    run_req(2'b00, 16'h1200, 8'h01, 1'b1, 16'h1201);
    check_val("force_cyc", n_cyc, 3);
    check_val("force_pc", {31'h0, got_pc}, 32'd0);

    // reserved mode behaves as abs
    run_req(2'b11, 16'h12F0, 8'h20, 1'b0, 16'h1310);
    check_val("m11_cyc", n_cyc, 3);
    check_val("m11_pc", {31'h0, got_pc}, 32'd1);

    // reset during HI
    @(negedge clk);
    req_valid = 1'b1; mode = 2'b00; base = 16'h12F0; index = 8'h20; force_fix = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("mid_in_hi", {30'h0, fsm_state}, 32'd2);
    reset_n = 1'b0;
    #1;
    check_val("mid_busy", {31'h0, busy}, 32'd0);
    check_val("mid_done", {31'h0, done}, 32'd0);
    check_val("mid_addr", {16'h0, addr}, 32'd0);
    check_val("mid_pc", {31'h0, page_cross}, 32'd0);
    check_val("mid_alu", {7'h0, alu_a, alu_b, alu_carry_in, alu_operation}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_req(2'b00, 16'h0300, 8'h04, 1'b0, 16'h0304);
    check_val("post_rst_cyc", n_cyc, 2);

    // req_valid held high while busy -> one transaction
    @(negedge clk);
    req_valid = 1'b1; mode = 2'b00; base = 16'h12F0; index = 8'h20; force_fix = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8 && n_done == 0; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        req_valid = 1'b0;
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("hold_one_txn", n_done, 1);
    check_val("hold_addr", {16'h0, addr}, 32'h1310);
    check_val("hold_idle", {31'h0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
